// File: rtl/toggle_counter.sv
// -----------------------------------------------------------------------------
// toggle_counter
//
// Multi-mode WIDTH-bit register. It can toggle a masked set of bits, count up,
// count down or load in parallel. A one-cycle terminal-count pulse is raised
// after an up step taken from all-ones or a down step taken from zero.
//
// Parameters
//   WIDTH  register width in bits, 1..32 (default 4)
//
// Ports
//   clk    rising-edge clock; all state changes happen on this edge
//   reset  synchronous active-low reset; forces q=0 and tc=0
//   en     operation enable; 0 holds q and clears tc
//   mode   00 toggle (q ^= t), 01 count up, 10 count down, 11 load d
//   t      per-bit toggle mask, used in toggle mode
//   d      parallel load data, used in load mode
//   q      registered state
//   qn     combinational complement of q
//   tc     registered terminal-count pulse
//
// Build option
//   TOGGLE_COUNTER_SAT_EN  when defined, up mode holds at all-ones and down
//                          mode holds at zero. tc still pulses on every
//                          attempt to step past the limit. When undefined,
//                          the counter wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module toggle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Declaration initialisers give a defined state at time zero, before the
    // first reset edge. On FPGA targets they also set the power-up value.
    logic [WIDTH-1:0] q_reg  = '0;
    logic             tc_reg = 1'b0;

    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic [WIDTH-1:0] toggle_next;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] down_next;
    logic             at_max;
    logic             at_min;

    assign at_max = (q_reg == ALL_ONES);
    assign at_min = (q_reg == ALL_ZERO);

    // Each bit behaves as an independent T flip-flop driven by its mask bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tff
            assign toggle_next[gi] = t[gi] ? ~q_reg[gi] : q_reg[gi];
        end
    endgenerate

`ifdef TOGGLE_COUNTER_SAT_EN
    // Saturating build: stay at the limit instead of wrapping.
    assign up_next   = at_max ? q_reg : (q_reg + ONE);
    assign down_next = at_min ? q_reg : (q_reg - ONE);
`else
    // Wrapping build: the arithmetic naturally wraps modulo 2^WIDTH.
    assign up_next   = q_reg + ONE;
    assign down_next = q_reg - ONE;
`endif

    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (en) begin
            case (mode)
                MODE_TOGGLE: q_next = toggle_next;
                MODE_UP: begin
                    q_next  = up_next;
                    tc_next = at_max;
                end
                MODE_DOWN: begin
                    q_next  = down_next;
                    tc_next = at_min;
                end
                MODE_LOAD: q_next = d;
                default: begin
                    q_next  = q_reg;
                    tc_next = 1'b0;
                end
            endcase
        end
    end

    // Reset also clears tc_reg, so a terminal event that was pending when
    // reset arrived never appears on tc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    assign q  = q_reg;
    assign qn = ~q_reg;
    assign tc = tc_reg;

endmodule

// File: tb/tb_toggle_counter.sv
// -----------------------------------------------------------------------------
// tb_toggle_counter
//
// Directed scenarios followed by randomized traffic for toggle_counter with
// WIDTH=4. A behavioural model (plain integer arithmetic) predicts q and tc.
// Prints one line per transaction and a final summary line.
// -----------------------------------------------------------------------------
module tb_toggle_counter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         tc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int mq  = 0;
    bit mtc = 1'b0;

    toggle_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .t     (t),
        .d     (d),
        .q     (q),
        .qn    (qn),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    // Advances the model by one edge using the currently driven inputs.
    task automatic model_step();
        if (!reset) begin
            mq  = 0;
            mtc = 1'b0;
        end else if (!en) begin
            mtc = 1'b0;
        end else begin
            case (mode)
                2'b00: begin
                    mq  = mq ^ int'(t);
                    mtc = 1'b0;
                end
                2'b01: begin
                    mtc = (mq == MAX);
`ifdef TOGGLE_COUNTER_SAT_EN
                    if (mq != MAX) mq = mq + 1;
`else
                    mq = (mq + 1) % (MAX + 1);
`endif
                end
                2'b10: begin
                    mtc = (mq == 0);
`ifdef TOGGLE_COUNTER_SAT_EN
                    if (mq != 0) mq = mq - 1;
`else
                    mq = (mq + MAX) % (MAX + 1);
`endif
                end
                default: begin
                    mq  = int'(d);
                    mtc = 1'b0;
                end
            endcase
        end
    endtask

    // Drives one transaction, takes one edge, samples 1 time unit later.
    task automatic cycle(input bit r, input bit e, input logic [1:0] m,
                         input logic [W-1:0] tt, input logic [W-1:0] dd);
        reset = r;
        en    = e;
        mode  = m;
        t     = tt;
        d     = dd;
        model_step();
        @(posedge clk);
        #1;
        $display("cyc reset=%b en=%b mode=%b t=%b d=%b -> q=%b qn=%b tc=%b",
                 r, e, m, tt, dd, q, qn, tc);
    endtask

    task automatic test_reset();
        // Defined state before the first edge
        #1;
        n_cmp++;
        if (q !== 4'b0000 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL init q=%b tc=%b expected q=0000 tc=0", q, tc);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
            n_cmp++;
            if (q !== 4'b0000 || qn !== 4'b1111 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_%0d q=%b qn=%b tc=%b expected q=0000 qn=1111 tc=0",
                         i, q, qn, tc);
            end
        end
    endtask

    task automatic test_toggle();
        logic [W-1:0] exp_q [2];
        exp_q[0] = 4'b1010;
        exp_q[1] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 2'b00, 4'b1010, 4'b0000);
            n_cmp++;
            if (q !== exp_q[i] || qn !== ~exp_q[i] || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle_%0d q=%b qn=%b tc=%b expected q=%b tc=0",
                         i, q, qn, tc, exp_q[i]);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] last_q;
`ifdef TOGGLE_COUNTER_SAT_EN
        last_q = 4'b1111;
`else
        last_q = 4'b0000;
`endif
        cycle(1'b1, 1'b1, 2'b11, 4'b0000, 4'b1110);
        n_cmp++;
        if (q !== 4'b1110 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_1110 q=%b tc=%b expected q=1110 tc=0", q, tc);
        end
        cycle(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== 4'b1111 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL up_1 q=%b tc=%b expected q=1111 tc=0", q, tc);
        end
        cycle(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== last_q || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL up_wrap q=%b tc=%b expected q=%b tc=1", q, tc, last_q);
        end
        // Pulse lasts exactly one cycle
        cycle(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== last_q || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL up_pulse_end q=%b tc=%b expected q=%b tc=0", q, tc, last_q);
        end
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] last_q;
`ifdef TOGGLE_COUNTER_SAT_EN
        last_q = 4'b0000;
`else
        last_q = 4'b1111;
`endif
        cycle(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0001);
        n_cmp++;
        if (q !== 4'b0001 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_0001 q=%b tc=%b expected q=0001 tc=0", q, tc);
        end
        cycle(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== 4'b0000 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL down_1 q=%b tc=%b expected q=0000 tc=0", q, tc);
        end
        cycle(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== last_q || qn !== ~last_q || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap q=%b qn=%b tc=%b expected q=%b tc=1",
                     q, qn, tc, last_q);
        end
    endtask

    task automatic test_hold();
        cycle(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 2'b01, 4'b1111, 4'b0101);
            n_cmp++;
            if (q !== 4'b0110 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d q=%b tc=%b expected q=0110 tc=0", i, q, tc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q_up;
        logic [W-1:0] q_dn;
        logic         tc_dn;
`ifdef TOGGLE_COUNTER_SAT_EN
        q_up  = 4'b1111;
        q_dn  = 4'b1110;
        tc_dn = 1'b0;
`else
        q_up  = 4'b0000;
        q_dn  = 4'b1111;
        tc_dn = 1'b1;
`endif
        cycle(1'b1, 1'b1, 2'b11, 4'b0000, 4'b1111);
        cycle(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== q_up || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_up q=%b tc=%b expected q=%b tc=1", q, tc, q_up);
        end
        cycle(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== q_dn || tc !== tc_dn) begin
            n_fail++;
            $display("FAIL b2b_down q=%b tc=%b expected q=%b tc=%b", q, tc, q_dn, tc_dn);
        end
    endtask

    task automatic test_reset_mid_count();
        cycle(1'b1, 1'b1, 2'b11, 4'b0000, 4'b1111);
        // Assert reset between edges: q must not move until the next edge
        reset = 1'b0;
        en    = 1'b1;
        mode  = 2'b01;
        model_step();
        #2;
        n_cmp++;
        if (q !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_async q=%b expected q=1111", q);
        end
        @(posedge clk);
        #1;
        $display("cyc reset=0 en=1 mode=01 (at 1111) -> q=%b qn=%b tc=%b", q, qn, tc);
        n_cmp++;
        if (q !== 4'b0000 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap q=%b tc=%b expected q=0000 tc=0", q, tc);
        end
        cycle(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000);
        n_cmp++;
        if (q !== 4'b0001 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after q=%b tc=%b expected q=0001 tc=0", q, tc);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q;
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(15) != 0), ($urandom_range(3) != 0),
                  2'($urandom_range(3)), 4'($urandom), 4'($urandom));
            exp_q = 4'(mq);
            n_cmp++;
            if (q !== exp_q || qn !== ~exp_q || tc !== mtc) begin
                n_fail++;
                $display("FAIL random_%0d q=%b qn=%b tc=%b expected q=%b qn=%b tc=%b",
                         i, q, qn, tc, exp_q, ~exp_q, mtc);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        mode  = 2'b01;
        t     = '0;
        d     = '0;
        test_reset();
        test_toggle();
        test_up_wrap();
        test_down_wrap();
        test_hold();
        test_back_to_back();
        test_reset_mid_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
